// File: rtl/expr_ctrl_pkg.sv
// Shared types and constants for the expr recognizer stream controller.
// Each FIFO entry carries one character plus an overflow tag used on ';' entries.
package expr_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFeed,
    StDone
  } state_e;

  localparam logic [7:0] SEMI = 8'h3B;
  localparam logic [7:0] NUL  = 8'h00;

  localparam int unsigned EntryW = 9;

  typedef struct packed {
    logic       tag;
    logic [7:0] chr;
  } entry_t;

endpackage

// File: rtl/expr_fifo.sv
// Synchronous FIFO with combinational head output and occupancy counter.
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module expr_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 9,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  localparam int unsigned   AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_en, pop_en;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LastIdx) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_en ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/expr_stream_ctrl.sv
// Buffers ';'-terminated expressions from a valid/ready stream and replays each one
// into the free-running expr recognizer, reporting one legality result per expression.
module expr_stream_ctrl
  import expr_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LW      = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic [7:0]    expr_in,
  output logic          expr_clr,
  input  logic          expr_out,
  output logic          res_valid,
  output logic          res_ok,
  output logic          res_ovf,
  output logic [LW-1:0] res_len
);
  localparam int unsigned   CW     = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] MaxLen = LW'(MAX_LEN);

  state_e                state_q, state_d;
  logic [LW-1:0]         wlen_q, wlen_d, rlen_q, rlen_d, res_len_q, res_len_d;
  logic                  ovf_pend_q, ovf_pend_d, res_ok_q, res_ok_d, res_ovf_q, res_ovf_d;
  logic [CW-1:0]         expr_cnt_q, expr_cnt_d;
  logic                  accept, is_semi, expr_inc, expr_dec;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [EntryW-1:0]     fifo_dout;
  entry_t                push_entry, head;

  expr_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(EntryW),
    .CW   (CW)
  ) u_fifo (
    .clk  (clk),
    .clr  (clr),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  (push_entry),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  assign head      = fifo_dout;
  assign in_ready  = ~fifo_full;
  assign accept    = in_valid & in_ready;
  assign is_semi   = (in_data == SEMI);
  assign res_ok    = res_ok_q;
  assign res_ovf   = res_ovf_q;
  assign res_len   = res_len_q;

  // Write side: characters past MAX_LEN are dropped and flagged on the terminating ';'.
  always_comb begin
    wlen_d     = wlen_q;
    ovf_pend_d = ovf_pend_q;
    fifo_push  = 1'b0;
    expr_inc   = 1'b0;
    push_entry = '{tag: 1'b0, chr: in_data};
    if (accept) begin
      if (is_semi) begin
        fifo_push      = 1'b1;
        push_entry.tag = ovf_pend_q;
        wlen_d         = '0;
        ovf_pend_d     = 1'b0;
        expr_inc       = 1'b1;
      end else if (wlen_q != MaxLen) begin
        fifo_push = 1'b1;
        wlen_d    = wlen_q + LW'(1);
      end else begin
        ovf_pend_d = 1'b1;
      end
    end
  end

  always_comb begin
    unique case ({expr_inc, expr_dec})
      2'b10:   expr_cnt_d = expr_cnt_q + CW'(1);
      2'b01:   expr_cnt_d = expr_cnt_q - CW'(1);
      default: expr_cnt_d = expr_cnt_q;
    endcase
  end

  // Read side: the recognizer is held in clear except while an expression streams.
  always_comb begin
    state_d   = state_q;
    rlen_d    = rlen_q;
    res_ok_d  = res_ok_q;
    res_ovf_d = res_ovf_q;
    res_len_d = res_len_q;
    expr_in   = NUL;
    expr_clr  = 1'b1;
    fifo_pop  = 1'b0;
    expr_dec  = 1'b0;
    res_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        rlen_d = '0;
        if (expr_cnt_q != '0) state_d = StFeed;
      end
      StFeed: begin
        expr_clr = 1'b0;
        expr_in  = head.chr;
        fifo_pop = 1'b1;
        if (head.chr == SEMI) begin
          // expr_out reflects the last real character applied on the previous edge.
          res_ok_d  = expr_out & (rlen_q != '0) & ~head.tag;
          res_ovf_d = head.tag;
          res_len_d = rlen_q;
          rlen_d    = '0;
          expr_dec  = 1'b1;
          state_d   = StDone;
        end else begin
          rlen_d = rlen_q + LW'(1);
        end
      end
      StDone: begin
        res_valid = 1'b1;
        state_d   = (expr_cnt_q != '0) ? StFeed : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= StIdle;
      wlen_q     <= '0;
      rlen_q     <= '0;
      ovf_pend_q <= 1'b0;
      expr_cnt_q <= '0;
      res_ok_q   <= 1'b0;
      res_ovf_q  <= 1'b0;
      res_len_q  <= '0;
    end else begin
      state_q    <= state_d;
      wlen_q     <= wlen_d;
      rlen_q     <= rlen_d;
      ovf_pend_q <= ovf_pend_d;
      expr_cnt_q <= expr_cnt_d;
      res_ok_q   <= res_ok_d;
      res_ovf_q  <= res_ovf_d;
      res_len_q  <= res_len_d;
    end
  end

  // Every buffered expression owns at least its ';' entry, so FEED never sees an empty FIFO.
  a_feed_nonempty: assert property (@(posedge clk) disable iff (clr)
    (state_q == StFeed) |-> !fifo_empty);
  a_cnt_le_occ: assert property (@(posedge clk) disable iff (clr)
    expr_cnt_q <= fifo_count);

endmodule

// File: tb/tb_expr_stream_ctrl.sv
// Directed bench for expr_stream_ctrl: a behavioural scoreboard predicts the streamed
// characters and per-expression results; a stub recognizer drives expr_out.
module tb_expr_stream_ctrl;
  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned LW      = 4;

  typedef logic [7:0] ch_t;
  typedef struct {
    bit ok;
    bit ovf;
    int len;
  } res_t;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic [7:0]    expr_in;
  logic          expr_clr;
  logic          expr_out;
  logic          res_valid, res_ok, res_ovf;
  logic [LW-1:0] res_len;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   saw_full = 1'b0;
  logic prev_clr_out = 1'b1;
  int   rec_q = 0;

  ch_t  cur[$];
  ch_t  exp_chars[$];
  res_t exp_res[$];
  int   res_cyc_q[$];
  int   start_cyc_q[$];

  expr_stream_ctrl u_dut (
    .clk      (clk),
    .clr      (clr),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .expr_in  (expr_in),
    .expr_clr (expr_clr),
    .expr_out (expr_out),
    .res_valid(res_valid),
    .res_ok   (res_ok),
    .res_ovf  (res_ovf),
    .res_len  (res_len)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit is_digit(input ch_t c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic bit is_op(input ch_t c);
    return (c == 8'h2B) || (c == 8'h2D) || (c == 8'h2A) || (c == 8'h2F);
  endfunction

  // Stub recognizer: 0 start, 1 after digit (legal), 2 after operator, 3 error.
  function automatic int rec_next(input int s, input ch_t c);
    case (s)
      0:       return is_digit(c) ? 1 : 3;
      1:       return is_digit(c) ? 1 : (is_op(c) ? 2 : 3);
      2:       return is_digit(c) ? 1 : 3;
      default: return 3;
    endcase
  endfunction

  always @(posedge clk) rec_q <= expr_clr ? 0 : rec_next(rec_q, expr_in);
  assign expr_out = (rec_q == 1);

  // Whole-string legality: digits and binary operators, starting and ending with a digit.
  function automatic bit legal(input ch_t s[$]);
    if (s.size() == 0) return 1'b0;
    if (!is_digit(s[0]) || !is_digit(s[s.size()-1])) return 1'b0;
    for (int i = 1; i < s.size(); i++)
      if (!is_digit(s[i]) && !(is_op(s[i]) && is_digit(s[i-1]))) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_accept(input ch_t b);
    if (b != 8'h3B) begin
      cur.push_back(b);
    end else begin
      ch_t  s[$];
      res_t r;
      int   n;
      n     = cur.size();
      r.len = (n > MAX_LEN) ? MAX_LEN : n;
      r.ovf = (n > MAX_LEN);
      for (int i = 0; i < r.len; i++) begin
        s.push_back(cur[i]);
        exp_chars.push_back(cur[i]);
      end
      exp_chars.push_back(8'h3B);
      r.ok = !r.ovf && legal(s);
      exp_res.push_back(r);
      cur.delete();
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Compare process: every streamed character and every result pulse against the model.
  always @(negedge clk) begin
    if (!clr) begin
      if (!in_ready) saw_full = 1'b1;
      if (!expr_clr) begin
        if (prev_clr_out) start_cyc_q.push_back(cyc);
        if (exp_chars.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL stream_extra: got char 0x%0h, expected no character", expr_in);
        end else begin
          check("expr_in", 32'(expr_in), 32'(exp_chars.pop_front()));
        end
      end
      prev_clr_out = expr_clr;
      if (res_valid) begin
        res_cyc_q.push_back(cyc);
        if (exp_res.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL res_extra: got res_valid=1, expected no result");
        end else begin
          res_t r;
          r = exp_res.pop_front();
          check("res_ok", 32'(res_ok), 32'(r.ok));
          check("res_ovf", 32'(res_ovf), 32'(r.ovf));
          check("res_len", 32'(res_len), 32'(r.len));
        end
      end
    end
  end

  task automatic finish_fatal(input string why);
    $display("FAIL %s: got timeout, expected progress", why);
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "bench aborted");
  endtask

  // Drives bytes back to back; called and returns at posedge+1.
  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      int g;
      g        = 0;
      in_valid = 1'b1;
      in_data  = s[i];
      while (!in_ready) begin
        @(posedge clk);
        #1;
        g++;
        if (g > 2000) finish_fatal("push_stall");
      end
      @(posedge clk);
      #1;
      model_accept(s[i]);
      acc_cyc = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while ((exp_res.size() != 0 || exp_chars.size() != 0) && g < 400) begin
      @(posedge clk);
      g++;
    end
    repeat (2) @(posedge clk);
    #1;
    check({name, "_pending"}, 32'(exp_res.size() + exp_chars.size()), 32'd0);
  endtask

  task automatic check_res(input string name, input bit ok, input bit ovf, input int len);
    check({name, "_ok"}, 32'(res_ok), 32'(ok));
    check({name, "_ovf"}, 32'(res_ovf), 32'(ovf));
    check({name, "_len"}, 32'(res_len), 32'(len));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    check({name, "_expr_clr"}, 32'(expr_clr), 32'd1);
    check({name, "_expr_in"}, 32'(expr_in), 32'd0);
    check({name, "_res_valid"}, 32'(res_valid), 32'd0);
    check_res(name, 1'b0, 1'b0, 0);
  endtask

  initial begin
    #200000;
    finish_fatal("watchdog");
  end

  initial begin
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    clr = 1'b0;

    // Single expression with idle reader: result 7 cycles after the ';' edge.
    res_cyc_q.delete();
    push_str("1+2*3;");
    drain("t1");
    check_res("t1", 1'b1, 1'b0, 5);
    if (res_cyc_q.size() > 0) check("t1_latency", 32'(res_cyc_q[0] - acc_cyc), 32'd7);

    push_str("1+;");
    drain("t2a");
    check_res("t2a", 1'b0, 1'b0, 2);
    push_str(";");
    drain("t2b");
    check_res("t2b", 1'b0, 1'b0, 0);

    push_str("123456789+1;");
    drain("t3");
    check_res("t3", 1'b0, 1'b1, 8);

    // Reader busy on a long expression so the following two are fully buffered.
    res_cyc_q.delete();
    start_cyc_q.delete();
    push_str("1+2+3+4;1;2*3;");
    drain("t4");
    check_res("t4", 1'b1, 1'b0, 3);
    check("t4_results", 32'(res_cyc_q.size()), 32'd3);
    if (res_cyc_q.size() == 3 && start_cyc_q.size() == 3)
      for (int k = 0; k < 2; k++)
        check("t4_clr_gap", 32'(start_cyc_q[k+1] - res_cyc_q[k]), 32'd1);

    // Reset while the third character is on expr_in.
    push_str("1+2*3;");
    begin
      int g;
      g = 0;
      while (!(expr_clr == 1'b0 && expr_in == 8'h32) && g < 50) begin
        @(posedge clk);
        #2;
        g++;
      end
      check("t5_reached_char3", 32'(expr_in), 32'h32);
    end
    clr = 1'b1;
    exp_chars.delete();
    exp_res.delete();
    cur.delete();
    prev_clr_out = 1'b1;
    #1;
    check_reset_outputs("t5_clr");
    @(posedge clk);
    #1;
    clr = 1'b0;
    push_str("7;");
    drain("t5");
    check_res("t5", 1'b1, 1'b0, 1);

    // Fill the FIFO: the reader needs two cycles per lone ';'.
    saw_full = 1'b0;
    res_cyc_q.delete();
    for (int k = 0; k < 36; k++) push_str(";");
    push_str("5*6;");
    drain("t6");
    check("t6_full_seen", 32'(saw_full), 32'd1);
    check("t6_results", 32'(res_cyc_q.size()), 32'd37);
    check_res("t6", 1'b1, 1'b0, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/expr_stream_ctrl.md
Name: expr_stream_ctrl

Overview:
Store-and-forward sequencer for the `expr` legality recognizer (clk, clr, in[7:0], out), which consumes one ASCII character on every clock edge and has no enable. The block accepts a byte stream over a valid/ready handshake and buffers each `;`-terminated expression. It then streams that expression into the recognizer on back-to-back cycles, samples `out` after the last character, reports one result per expression, and clears the recognizer between expressions.

Parameters:
DEPTH, 16, FIFO entries (9-bit each); must be >= MAX_LEN+1
MAX_LEN, 8, max characters per expression excluding `;`
LW, $clog2(MAX_LEN+1), width of length fields

Ports:
clk  in  1  clock, all state on rising edge
clr  in  1  reset, asynchronous, active-high
in_valid  in  1  upstream byte valid
in_data  in  8  upstream ASCII byte
in_ready  out  1  = FIFO not full
expr_in  out  8  character to recognizer
expr_clr  out  1  clear to recognizer
expr_out  in  1  recognizer Moore output (legal-so-far)
res_valid  out  1  one-cycle result pulse
res_ok  out  1  expression legal
res_ovf  out  1  expression exceeded MAX_LEN
res_len  out  LW  characters streamed (excl. `;`)

Behaviour:
- Reset (async, clr=1): FIFO empty, all counters 0, state IDLE. Outputs: in_ready=1, expr_clr=1, expr_in=8'h00, res_valid/res_ok/res_ovf=0, res_len=0. Reset mid-FEED discards the partial stream and all buffered bytes.
- Write side (handshake: accept when in_valid & in_ready):
  - Non-`;` byte with wlen<MAX_LEN: push {0,byte}, wlen++.
  - Non-`;` byte with wlen==MAX_LEN: drop the byte, set ovf_pend.
  - `;` (8'h3B): push {ovf_pend,`;`}, wlen=0, ovf_pend=0, expr_cnt++.
- expr_cnt counts complete expressions in the FIFO. If an increment and a decrement happen in the same cycle, expr_cnt is unchanged.
- Read FSM, state IDLE:
  - expr_clr=1, expr_in=0.
  - Go to FEED when expr_cnt>0. rlen=0.
- Read FSM, state FEED:
  - Head is non-`;`: expr_in=head, expr_clr=0, pop, rlen++.
  - Head is `;`: expr_in=`;`, expr_clr=0, pop. Register res_ok=expr_out & (rlen!=0) & !tag, res_ovf=tag, res_len=rlen. expr_cnt--. Go to DONE.
  - The FIFO is never empty in FEED, because the whole expression is already buffered.
- Read FSM, state DONE:
  - res_valid=1 for exactly this cycle. expr_clr=1.
  - Go to FEED if expr_cnt>0, else IDLE.
- Clear sequencing: expr_clr=1 throughout the sampling cycle is forbidden. This keeps sampling correct whether the recognizer's clr is synchronous or asynchronous.
- Latency: from the `;` accept edge to res_valid with an idle reader = rlen+2 cycles. Back-to-back expressions are separated by exactly one expr_clr=1 cycle (DONE).
- Empty expression (`;` alone): res_ok=0, res_len=0, no characters streamed.
- FIFO pointers wrap modulo DEPTH; the full/empty distinction uses an occupancy counter. Push and pop in the same cycle leave occupancy unchanged. No push is possible while full.
- res_ok, res_ovf and res_len hold their values until the next DONE.

Decomposition:
- Package expr_ctrl_pkg:
  - state enum IDLE/FEED/DONE
  - SEMI=8'h3B, NUL=8'h00
  - 9-bit entry layout {tag,char}
- Sub-module expr_fifo: synchronous FIFO with DEPTH and WIDTH parameters.
  - Ports: push, pop, din, dout (head, combinational), full, empty, count.
  - Async active-high clr.

Test Plan:
- Idle reader, push "1+2*3;" on consecutive cycles: expr_in shows '1','+','2','*','3' with expr_clr=0. res_valid fires 7 cycles after the `;` edge with res_ok=1, res_len=5, res_ovf=0.
- Push "1+;" -> res_ok=0, res_len=2. Push ";" -> res_ok=0, res_len=0, and expr_clr never deasserts for a character.
- Push "123456789+1;" (MAX_LEN=8): bytes 9 onward are dropped. Result: res_ovf=1, res_ok=0, res_len=8.
- Push "1;2*3;" back-to-back: two res_valid pulses; the second result has res_ok=1, res_len=3. expr_clr is high exactly one cycle between the '1' stream and the '2' stream.
- Assert clr for 1 cycle while FEED is on the 3rd char of "1+2*3;": all outputs return to reset values immediately. Pushing "7;" afterwards gives res_ok=1, res_len=1.
- Hold the reader busy and push until full (16 entries): in_ready=0, extra in_valid bytes are not accepted, and no byte is lost or duplicated after draining.
